// File: rtl/ldtu_readout_sequencer_if.sv
// Handshake and data bundle between the readout sequencer, the output FIFO,
// the ATU test-data source and the serializer lanes.
interface ldtu_readout_sequencer_if #(
  parameter int unsigned Nbits_32 = 32
);
  logic                CALIBRATION_BUSY;
  logic                TEST_ENABLE;
  logic                handshake;
  logic                fifo_empty;
  logic [Nbits_32-1:0] DATA32_DTU;
  logic [Nbits_32-1:0] DATA32_ATU;
  logic                read_signal;
  logic                dp_reset;
  logic                atu_sel;
  logic [Nbits_32-1:0] DATA32_OUT;
  logic [2:0]          state_out;
  logic                drain_lost;

  // Environment side: mode requests, FIFO and ATU sources, serializer sink.
  modport master (
    output CALIBRATION_BUSY, TEST_ENABLE, handshake, fifo_empty, DATA32_DTU, DATA32_ATU,
    input  read_signal, dp_reset, atu_sel, DATA32_OUT, state_out, drain_lost
  );

  // Sequencer side.
  modport slave (
    input  CALIBRATION_BUSY, TEST_ENABLE, handshake, fifo_empty, DATA32_DTU, DATA32_ATU,
    output read_signal, dp_reset, atu_sel, DATA32_OUT, state_out, drain_lost
  );
endinterface

// File: rtl/ldtu_readout_sequencer.sv
// LiTE-DTU readout sequencer: moves the readout path between sync, DTU readout,
// calibration blanking and ATU test passthrough, and picks the serializer word.
module ldtu_readout_sequencer #(
  parameter int unsigned         Nbits_32  = 32,
  parameter logic [Nbits_32-1:0] SYNC_WORD = 32'hEAAAAAAA,
  parameter logic [Nbits_32-1:0] IDLE_WORD = 32'hE0000000,
  parameter int unsigned         RST_HOLD  = 8,
  parameter int unsigned         DRAIN_MAX = 64
) (
  input logic                     CLK,
  input logic                     RST,
  ldtu_readout_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_CALIB   = 3'd3,
    ST_TEST    = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(RST_HOLD - 1);

  state_t              state;
  state_t              next_state;
  logic [7:0]          drain_cnt;
  logic [7:0]          hold_cnt;
  logic                drain_to_test;
  logic                drain_timeout;
  logic                rd_d;
  logic                dp_reset_q;
  logic                atu_sel_q;
  logic                drain_lost_q;
  logic [Nbits_32-1:0] data_out_q;
  logic [Nbits_32-1:0] pattern;

  assign bus.read_signal = ((state == ST_RUN) || (state == ST_DRAIN)) && !bus.fifo_empty;
  assign drain_timeout   = (drain_cnt == DRAIN_LAST);

  assign bus.state_out  = state;
  assign bus.dp_reset   = dp_reset_q;
  assign bus.atu_sel    = atu_sel_q;
  assign bus.drain_lost = drain_lost_q;
  assign bus.DATA32_OUT = data_out_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pattern = IDLE_WORD;
    if (state == ST_SYNC)      pattern = SYNC_WORD;
    else if (state == ST_TEST) pattern = bus.DATA32_ATU;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_SYNC: begin
        if (bus.CALIBRATION_BUSY) next_state = ST_CALIB;
        else if (bus.TEST_ENABLE) next_state = ST_TEST;
        else if (bus.handshake)   next_state = ST_RUN;
      end
      ST_RUN: begin
        if (bus.CALIBRATION_BUSY || bus.TEST_ENABLE) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A calibration request overrides a pending test target mid-drain.
        if (bus.fifo_empty || drain_timeout)
          next_state = (bus.CALIBRATION_BUSY || !drain_to_test) ? ST_CALIB : ST_TEST;
      end
      ST_CALIB: begin
        if (!bus.CALIBRATION_BUSY) next_state = ST_RELEASE;
      end
      ST_TEST: begin
        if (bus.CALIBRATION_BUSY) next_state = ST_CALIB;
        else if (!bus.TEST_ENABLE) next_state = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (bus.CALIBRATION_BUSY)     next_state = ST_CALIB;
        else if (bus.TEST_ENABLE)     next_state = ST_TEST;
        else if (hold_cnt == HOLD_LAST) next_state = ST_SYNC;
      end
      default: next_state = ST_SYNC;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= ST_SYNC;
      drain_cnt     <= '0;
      hold_cnt      <= '0;
      drain_to_test <= 1'b0;
      rd_d          <= 1'b0;
      dp_reset_q    <= 1'b1;
      atu_sel_q     <= 1'b0;
      drain_lost_q  <= 1'b0;
      data_out_q    <= SYNC_WORD;
    end else begin
      state     <= next_state;
      drain_cnt <= (state == ST_DRAIN && next_state == ST_DRAIN) ? drain_cnt + 8'd1 : 8'd0;
      hold_cnt  <= (state == ST_RELEASE && next_state == ST_RELEASE) ? hold_cnt + 8'd1 : 8'd0;
      if (state == ST_RUN)
        drain_to_test <= bus.TEST_ENABLE && !bus.CALIBRATION_BUSY;
      else if (state == ST_DRAIN && bus.CALIBRATION_BUSY)
        drain_to_test <= 1'b0;
      rd_d       <= bus.read_signal;
      // Registered from next-state so the datapath reset tracks the new mode edge-aligned.
      dp_reset_q <= (next_state == ST_CALIB) || (next_state == ST_TEST) || (next_state == ST_RELEASE);
      atu_sel_q  <= (next_state == ST_TEST);
      data_out_q <= rd_d ? bus.DATA32_DTU : pattern;
      if (state == ST_DRAIN && drain_timeout && !bus.fifo_empty)
        drain_lost_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ldtu_readout_sequencer.sv
// Self-checking bench for ldtu_readout_sequencer: directed mode walk-through,
// then randomized traffic against a cycle-level behavioural model.
module tb_ldtu_readout_sequencer;

  localparam logic [31:0] SYNC_W = 32'hEAAAAAAA;
  localparam logic [31:0] IDLE_W = 32'hE0000000;
  localparam int HOLD = 8;
  localparam int DMAX = 64;
  localparam int M_SYNC = 0, M_RUN = 1, M_DRAIN = 2, M_CALIB = 3, M_TEST = 4, M_REL = 5;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  ldtu_readout_sequencer_if #(.Nbits_32(32)) bus ();

  ldtu_readout_sequencer #(
    .Nbits_32 (32),
    .SYNC_WORD(SYNC_W),
    .IDLE_WORD(IDLE_W),
    .RST_HOLD (HOLD),
    .DRAIN_MAX(DMAX)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output FIFO contents as seen by the bench, and the behavioural model.
  logic [31:0] fifo[$];
  logic [31:0] out_log[$];
  int          m_mode = M_SYNC;
  int          m_cnt = 0;
  bit          m_to_test = 0;
  bit          m_lost = 0;
  bit          m_pending = 0;
  bit          m_valid = 0;
  logic [31:0] m_pending_word = '0;
  int          rd_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  function automatic logic [31:0] exp_pattern(input int mode, input logic [31:0] atu);
    if (mode == M_SYNC) return SYNC_W;
    if (mode == M_TEST) return atu;
    return IDLE_W;
  endfunction

  // One clock cycle: predict, clock, compare, then serve the FIFO read.
  task automatic tick();
    logic [31:0] exp_out;
    bit          exp_read;
    bit          cal, tst, empty;
    int          nxt;
    #1;
    exp_read = 1'b0;
    cal   = bus.CALIBRATION_BUSY;
    tst   = bus.TEST_ENABLE;
    empty = (fifo.size() == 0);
    if (rst && m_valid) begin
      exp_read = (m_mode == M_RUN || m_mode == M_DRAIN) && !empty;
      check("read_signal", 32'(bus.read_signal), 32'(exp_read));
    end
    if (bus.read_signal === 1'b1) rd_seen++;
    if (!rst) begin
      m_mode = M_SYNC; m_cnt = 0; m_to_test = 0; m_lost = 0; m_valid = 1;
      exp_out = SYNC_W;
    end else begin
      exp_out = m_pending ? m_pending_word : exp_pattern(m_mode, bus.DATA32_ATU);
      nxt = m_mode;
      case (m_mode)
        M_SYNC:  nxt = cal ? M_CALIB : tst ? M_TEST : bus.handshake ? M_RUN : M_SYNC;
        M_RUN: begin
          if (cal)      begin nxt = M_DRAIN; m_to_test = 0; end
          else if (tst) begin nxt = M_DRAIN; m_to_test = 1; end
        end
        M_DRAIN: begin
          if (cal) m_to_test = 0;
          if (empty || m_cnt + 1 >= DMAX) begin
            nxt = m_to_test ? M_TEST : M_CALIB;
            if (!empty) m_lost = 1;
          end
        end
        M_CALIB: if (!cal) nxt = M_REL;
        M_TEST:  nxt = cal ? M_CALIB : !tst ? M_REL : M_TEST;
        default: nxt = cal ? M_CALIB : tst ? M_TEST : (m_cnt + 1 >= HOLD) ? M_SYNC : M_REL;
      endcase
      m_cnt  = (nxt == m_mode) ? m_cnt + 1 : 0;
      m_mode = nxt;
    end
    @(posedge clk);
    #1;
    check("state_out", 32'(bus.state_out), 32'(m_mode));
    check("DATA32_OUT", bus.DATA32_OUT, exp_out);
    check("dp_reset", 32'(bus.dp_reset), (!rst || m_mode >= M_CALIB) ? 32'd1 : 32'd0);
    check("atu_sel", 32'(bus.atu_sel), (rst && m_mode == M_TEST) ? 32'd1 : 32'd0);
    check("drain_lost", 32'(bus.drain_lost), 32'(m_lost));
    out_log.push_back(bus.DATA32_OUT);
    m_pending = exp_read;
    if (exp_read) begin
      m_pending_word = fifo.pop_front();
      bus.DATA32_DTU = m_pending_word;
    end else begin
      bus.DATA32_DTU = $urandom();
    end
    bus.fifo_empty = (fifo.size() == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int hit;
    logic [31:0] want[5];

    rst = 1'b0;
    bus.CALIBRATION_BUSY = 1'b0;
    bus.TEST_ENABLE      = 1'b0;
    bus.handshake        = 1'b0;
    bus.fifo_empty       = 1'b1;
    bus.DATA32_DTU       = '0;
    bus.DATA32_ATU       = '0;

    // Step 1: reset, wait for sync, handshake.
    repeat (3) tick();
    check("rst_dp_reset", 32'(bus.dp_reset), 32'd1);
    check("rst_out", bus.DATA32_OUT, 32'hEAAAAAAA);
    rst = 1'b1;
    repeat (10) tick();
    check("sync_state", 32'(bus.state_out), 32'd0);
    check("sync_out", bus.DATA32_OUT, 32'hEAAAAAAA);
    check("sync_dp_reset", 32'(bus.dp_reset), 32'd0);
    bus.handshake = 1'b1;
    tick();
    check("enter_run", 32'(bus.state_out), 32'd1);

    // Step 2: three-word readout with two-cycle latency.
    out_log.delete();
    rd_seen = 0;
    push_word(32'h11111111); push_word(32'h22222222); push_word(32'h33333333);
    repeat (6) tick();
    check("run_reads", 32'(rd_seen), 32'd3);
    check("run_w1", out_log[1], 32'h11111111);
    check("run_w2", out_log[2], 32'h22222222);
    check("run_w3", out_log[3], 32'h33333333);
    check("run_idle", out_log[4], 32'hE0000000);

    // Step 3: calibration pulse drains five words, then an 8-cycle hold.
    out_log.delete();
    for (int i = 0; i < 5; i++) begin
      want[i] = 32'hC0DE0000 + 32'(i);
      push_word(want[i]);
    end
    bus.CALIBRATION_BUSY = 1'b1;
    repeat (20) tick();
    check("cal_state", 32'(bus.state_out), 32'd3);
    check("cal_dp_reset", 32'(bus.dp_reset), 32'd1);
    check("cal_fifo_left", 32'(fifo.size()), 32'd0);
    hit = 0;
    foreach (out_log[k]) if (hit < 5 && out_log[k] == want[hit]) hit++;
    check("drain_words", 32'(hit), 32'd5);
    bus.CALIBRATION_BUSY = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && bus.state_out != 3'd0; i++) begin
      tick();
      if (bus.dp_reset) n++;
    end
    check("hold_len", 32'(n), 32'd8);
    check("hold_exit", 32'(bus.state_out), 32'd0);
    check("no_loss", 32'(bus.drain_lost), 32'd0);

    // Step 4: FIFO never empties, drain times out after 64 cycles.
    for (int i = 0; i < 100 && bus.state_out != 3'd1; i++) tick();
    check("rerun", 32'(bus.state_out), 32'd1);
    for (int i = 0; i < 200; i++) push_word($urandom());
    bus.CALIBRATION_BUSY = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.state_out == 3'd2) n++;
      else if (n > 0) break;
    end
    check("drain_len", 32'(n), 32'd64);
    check("drain_exit", 32'(bus.state_out), 32'd3);
    check("lost_set", 32'(bus.drain_lost), 32'd1);
    bus.CALIBRATION_BUSY = 1'b0;
    bus.handshake = 1'b0;
    for (int i = 0; i < 100 && bus.state_out != 3'd0; i++) tick();
    check("lost_sticky", 32'(bus.drain_lost), 32'd1);

    // Step 5: reset clears loss flag; ATU passthrough, then calibration override.
    rst = 1'b0;
    fifo.delete();
    bus.fifo_empty = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("lost_cleared", 32'(bus.drain_lost), 32'd0);
    bus.TEST_ENABLE = 1'b1;
    bus.DATA32_ATU = 32'hA0000000;
    tick();
    check("test_state", 32'(bus.state_out), 32'd4);
    for (int i = 1; i <= 6; i++) begin
      bus.DATA32_ATU = 32'hA0000000 + 32'(i);
      tick();
      check("atu_follow", bus.DATA32_OUT, 32'hA0000000 + 32'(i));
      check("atu_sel_on", 32'(bus.atu_sel), 32'd1);
    end
    bus.CALIBRATION_BUSY = 1'b1;
    bus.TEST_ENABLE = 1'b0;
    tick();
    check("test_to_cal", 32'(bus.state_out), 32'd3);
    check("atu_sel_off", 32'(bus.atu_sel), 32'd0);

    // Step 6: calibration re-asserts in RELEASE cycle 4, hold restarts.
    repeat (3) tick();
    bus.CALIBRATION_BUSY = 1'b0;
    repeat (4) tick();
    check("in_release", 32'(bus.state_out), 32'd5);
    bus.CALIBRATION_BUSY = 1'b1;
    tick();
    check("rel_to_cal", 32'(bus.state_out), 32'd3);
    repeat (2) tick();
    bus.CALIBRATION_BUSY = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && bus.state_out != 3'd0; i++) begin
      tick();
      if (bus.dp_reset) n++;
    end
    check("rehold_len", 32'(n), 32'd8);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) bus.CALIBRATION_BUSY = !bus.CALIBRATION_BUSY;
      if ($urandom_range(0, 99) < 4) bus.TEST_ENABLE = !bus.TEST_ENABLE;
      bus.handshake = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 4) push_word($urandom());
      if ($urandom_range(0, 99) == 0) for (int k = 0; k < 80; k++) push_word($urandom());
      bus.DATA32_ATU = $urandom();
      rst = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
